// File: rtl/mic_sample_fifo.sv
// mic_sample_fifo: PDM mic bit-clock divider and 48-bit word capture
// FIFO, drained as a first-word-fall-through byte stream (MSB first).
//
// Ports:
//   clk       fabric clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset
//   micData   48 mic bits, panel 1 in [47:40] .. panel 6 in [7:0]
//   micEn     capture enable, gates the per-period word write
//   micClk    registered mic bit clock, CLK_DIV clk per period, 50% duty
//   enable    read-advance strobe from the packet transmitter
//   data      current head byte, 0x00 while the FIFO is empty
//   fullEn    stored word count >= PACKET_SAMPLES
//   overflow  sticky, a captured word was dropped on a full FIFO
//   underflow sticky, enable was seen while the FIFO was empty

module mic_sample_fifo #(
  parameter int CLK_DIV        = 64,
  parameter int DEPTH          = 1024,
  parameter int PACKET_SAMPLES = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] micData,
  input  logic        micEn,
  output logic        micClk,
  input  logic        enable,
  output logic [7:0]  data,
  output logic        fullEn,
  output logic        overflow,
  output logic        underflow
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_PKT  = CW'(PACKET_SAMPLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    SEL_LAST = 3'd5;

  // ------------------------------------------------------------
  // Bit-clock divider and capture strobe
  // ------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic          strobe;

  // Strobe on the last cycle of the period, just before micClk falls.
  assign strobe  = (div_cnt == DIV_LAST);
  assign div_nxt = strobe ? '0 : div_cnt + DW'(1);

  // ------------------------------------------------------------
  // FIFO state
  // ------------------------------------------------------------
  logic [47:0]   mem [DEPTH];
  logic [47:0]   mic_q;
  logic [47:0]   head_q;
  logic [47:0]   head_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_inc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [2:0]    sel;

  logic empty;
  logic wr_req;
  logic wr_en;
  logic rd_adv;
  logic pop;

  assign empty  = (count == '0);
  assign wr_req = strobe & micEn;
  assign wr_en  = wr_req & (count != CNT_FULL);
  assign rd_adv = enable & ~empty;
  assign pop    = rd_adv & (sel == SEL_LAST);
  assign rd_inc = rd_ptr + PW'(1);

  // ------------------------------------------------------------
  // Head word prefetch
  // head_q always holds mem[rd_ptr] while count > 0, so the byte
  // mux never waits on the array and a pop is bubble-free.
  // ------------------------------------------------------------
  always_comb begin
    head_nxt = head_q;
    if (pop) begin
      if (count != CNT_ONE)
        head_nxt = mem[rd_inc];
      else if (wr_en)
        // Last word leaves as a new one lands: take it directly,
        // it is not in the array until this edge.
        head_nxt = mic_q;
    end else if (empty && wr_en) begin
      head_nxt = mic_q;
    end
  end

  always_comb begin
    count_nxt = count;
    unique case ({wr_en, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // ------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      micClk    <= 1'b0;
      mic_q     <= '0;
      head_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sel       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      micClk  <= (div_nxt >= DIV_HALF);
      mic_q   <= micData;
      head_q  <= head_nxt;
      count   <= count_nxt;
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_inc;
      if (rd_adv)
        sel <= pop ? 3'd0 : sel + 3'd1;
      if (wr_req && !wr_en)
        overflow <= 1'b1;
      if (enable && empty)
        underflow <= 1'b1;
    end
  end

  // Word storage carries no reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= mic_q;
  end

  // ------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------
  always_comb begin
    data = 8'h00;
    if (!empty) begin
      case (sel)
        3'd0:    data = head_q[47:40];
        3'd1:    data = head_q[39:32];
        3'd2:    data = head_q[31:24];
        3'd3:    data = head_q[23:16];
        3'd4:    data = head_q[15:8];
        3'd5:    data = head_q[7:0];
        default: data = 8'h00;
      endcase
    end
  end

  assign fullEn = (count >= CNT_PKT);

endmodule

// File: tb/tb_mic_sample_fifo.sv
// tb_mic_sample_fifo: randomized and directed checks of mic_sample_fifo
// against a queue-based word/byte reference model.

module tb_mic_sample_fifo;

  localparam int CLK_DIV = 64;
  localparam int DEPTH   = 1024;
  localparam int PKT     = 400;
  localparam int WPB     = 6;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [47:0] micData = '0;
  logic        micEn   = 1'b0;
  logic        enable  = 1'b0;
  logic        micClk;
  logic [7:0]  data;
  logic        fullEn;
  logic        overflow;
  logic        underflow;

  logic        rst16_n = 1'b0;
  logic [47:0] md16    = '0;
  logic        me16    = 1'b0;
  logic        en16    = 1'b0;
  logic        mclk16;
  logic [7:0]  data16;
  logic        full16;
  logic        ovf16;
  logic        unf16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] q[$];
  int          m_sel  = 0;
  int          m_cyc  = 0;
  logic        m_ovf  = 1'b0;
  logic        m_unf  = 1'b0;
  logic [47:0] m_prev = '0;

  always #4 clk = ~clk;

  mic_sample_fifo #(
    .CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .PACKET_SAMPLES(PKT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .micData(micData),
    .micEn(micEn), .micClk(micClk), .enable(enable),
    .data(data), .fullEn(fullEn), .overflow(overflow),
    .underflow(underflow)
  );

  mic_sample_fifo #(
    .CLK_DIV(8), .DEPTH(16), .PACKET_SAMPLES(16)
  ) dut16 (
    .clk(clk), .rst_n(rst16_n), .micData(md16),
    .micEn(me16), .micClk(mclk16), .enable(en16),
    .data(data16), .fullEn(full16), .overflow(ovf16),
    .underflow(unf16)
  );

  // Reference model: one call per clock edge with that edge's inputs.
  task automatic model_step(input logic en, input logic me,
                            input logic [47:0] md);
    int n0;
    n0 = q.size();
    if (me && (m_cyc % CLK_DIV) == CLK_DIV - 1) begin
      if (n0 == DEPTH) m_ovf = 1'b1;
      else q.push_back(m_prev);
    end
    if (en) begin
      if (n0 == 0) m_unf = 1'b1;
      else if (m_sel == WPB - 1) begin
        m_sel = 0;
        void'(q.pop_front());
      end else m_sel++;
    end
    m_prev = md;
    m_cyc++;
  endtask

  function automatic logic [7:0] m_byte();
    logic [47:0] w;
    if (q.size() == 0) return 8'h00;
    w = q[0] >> (8 * (WPB - 1 - m_sel));
    return w[7:0];
  endfunction

  function automatic logic m_full();
    return q.size() >= PKT;
  endfunction

  function automatic logic m_mclk();
    return (m_cyc % CLK_DIV) >= CLK_DIV / 2;
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic en, input logic me,
                      input logic [47:0] md);
    enable  = en;
    micEn   = me;
    micData = md;
    @(posedge clk);
    model_step(en, me, md);
    @(negedge clk);
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    micEn   = 1'b0;
    micData = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_sel = 0; m_cyc = 0;
    m_ovf = 1'b0; m_unf = 1'b0;
    m_prev = '0;
  endtask

  task automatic test_reset();
    int first_rise;
    int highs;
    first_rise = -1;
    highs = 0;
    @(negedge clk);
    n_tests++;
    if ({micClk, data, fullEn, overflow, underflow} !== 12'h0) begin
      n_fail++;
      $display("FAIL rst_outputs got %h want 000",
               {micClk, data, fullEn, overflow, underflow});
    end
    do_reset();
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      tick(1'b0, 1'b0, rnd48());
      n_tests++;
      if (micClk !== m_mclk()) begin
        n_fail++;
        $display("FAIL rst_micclk cyc=%0d got %b want %b",
                 m_cyc, micClk, m_mclk());
      end
      n_tests++;
      if ({data, fullEn, overflow, underflow} !== 11'h0) begin
        n_fail++;
        $display("FAIL rst_idle cyc=%0d got %h want 000",
                 m_cyc, {data, fullEn, overflow, underflow});
      end
      if (micClk === 1'b1 && first_rise < 0) first_rise = m_cyc;
      if (micClk === 1'b1 && i < 2 * CLK_DIV) highs++;
    end
    n_tests++;
    if (first_rise !== CLK_DIV / 2) begin
      n_fail++;
      $display("FAIL rst_first_rise got %0d want %0d",
               first_rise, CLK_DIV / 2);
    end
    n_tests++;
    if (highs !== CLK_DIV) begin
      n_fail++;
      $display("FAIL rst_duty got %0d want %0d", highs, CLK_DIV);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < PKT * CLK_DIV; i++) begin
      tick(1'b0, 1'b1, 48'(m_cyc / CLK_DIV));
      n_tests++;
      if (data !== m_byte() || fullEn !== m_full()) begin
        n_fail++;
        $display("FAIL fill cyc=%0d got %h/%b want %h/%b",
                 m_cyc, data, fullEn, m_byte(), m_full());
      end
      n_tests++;
      if (overflow !== m_ovf || underflow !== m_unf) begin
        n_fail++;
        $display("FAIL fill_flags cyc=%0d got %b%b want %b%b",
                 m_cyc, overflow, underflow, m_ovf, m_unf);
      end
    end
    n_tests++;
    if (fullEn !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_fullen got %b want 1", fullEn);
    end
  endtask

  task automatic test_read_packet();
    for (int i = 0; i < PKT * WPB; i++) begin
      n_tests++;
      if (data !== m_byte()) begin
        n_fail++;
        $display("FAIL pkt_data byte=%0d got %h want %h",
                 i, data, m_byte());
      end
      tick(1'b1, 1'b1, 48'(m_cyc / CLK_DIV));
      n_tests++;
      if (fullEn !== m_full()) begin
        n_fail++;
        $display("FAIL pkt_fullen byte=%0d got %b want %b",
                 i, fullEn, m_full());
      end
    end
    n_tests++;
    if (underflow !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_flags got %b%b want 00", overflow, underflow);
    end
  endtask

  task automatic test_drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 6 * DEPTH) begin
      n_tests++;
      if (data !== m_byte()) begin
        n_fail++;
        $display("FAIL drain_data n=%0d got %h want %h",
                 guard, data, m_byte());
      end
      tick(1'b1, 1'b0, rnd48());
      guard++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_bound got %0d want 0", q.size());
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (data !== 8'h00 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_underflow got %h/%b want 00/1",
               data, underflow);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [7];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    do_reset();
    for (int i = 0; i < CLK_DIV; i++)
      tick(1'b0, 1'b1, 48'h0102_0304_0506);
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (data !== exp[i]) begin
        n_fail++;
        $display("FAIL single_byte i=%0d got %h want %h",
                 i, data, exp[i]);
      end
      if (i == 6) begin
        n_tests++;
        if (underflow !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early_unf got %b want 0", underflow);
        end
      end
      tick(1'b1, 1'b0, 48'h0102_0304_0506);
    end
    n_tests++;
    if (underflow !== 1'b1 || data !== 8'h00) begin
      n_fail++;
      $display("FAIL single_unf got %b/%h want 1/00", underflow, data);
    end
  endtask

  task automatic test_micen_off();
    do_reset();
    for (int i = 0; i < 3 * CLK_DIV; i++)
      tick(1'b0, 1'b1, rnd48());
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      tick(1'b0, 1'b0, rnd48());
      n_tests++;
      if (data !== m_byte() || fullEn !== m_full()) begin
        n_fail++;
        $display("FAIL micen_hold cyc=%0d got %h/%b want %h/%b",
                 m_cyc, data, fullEn, m_byte(), m_full());
      end
    end
    for (int i = 0; i < 3 * WPB; i++) begin
      n_tests++;
      if (data !== m_byte()) begin
        n_fail++;
        $display("FAIL micen_read i=%0d got %h want %h",
                 i, data, m_byte());
      end
      tick(1'b1, 1'b0, '0);
    end
    n_tests++;
    if (data !== 8'h00 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL micen_empty got %h/%b want 00/0", data, underflow);
    end
  endtask

  task automatic test_pop_on_strobe();
    int got;
    do_reset();
    for (int i = 0; i < 5 * CLK_DIV; i++)
      tick(1'b0, 1'b1, rnd48());
    while ((m_cyc % CLK_DIV) != CLK_DIV - WPB)
      tick(1'b0, 1'b1, rnd48());
    // Sixth enable lands on the capture strobe edge.
    for (int i = 0; i < WPB; i++) begin
      n_tests++;
      if (data !== m_byte()) begin
        n_fail++;
        $display("FAIL pos_read i=%0d got %h want %h",
                 i, data, m_byte());
      end
      tick(1'b1, 1'b1, rnd48());
    end
    got = 0;
    for (int i = 0; i < 5 * WPB; i++) begin
      n_tests++;
      if (data !== m_byte()) begin
        n_fail++;
        $display("FAIL pos_drain i=%0d got %h want %h",
                 i, data, m_byte());
      end
      tick(1'b1, 1'b0, '0);
      if (underflow === 1'b0) got++;
    end
    n_tests++;
    if (got !== 5 * WPB || data !== 8'h00) begin
      n_fail++;
      $display("FAIL pos_count got %0d/%h want %0d/00",
               got, data, 5 * WPB);
    end
    tick(1'b1, 1'b0, '0);
    n_tests++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pos_unf got %b want 1", underflow);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [47:0] w;
    w = 48'hFFEE_DDCC_BBAA;
    do_reset();
    tick(1'b1, 1'b1, w);
    for (int i = 1; i < CLK_DIV + 40; i++)
      tick(1'b0, 1'b1, w);
    tick(1'b1, 1'b1, w);
    tick(1'b1, 1'b1, w);
    n_tests++;
    if (micClk !== 1'b1 || data !== m_byte() || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre got %b/%h/%b want 1/%h/1",
               micClk, data, underflow, m_byte());
    end
    enable = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({micClk, data, fullEn, overflow, underflow} !== 12'h0) begin
      n_fail++;
      $display("FAIL mid_async got %h want 000",
               {micClk, data, fullEn, overflow, underflow});
    end
    enable = 1'b0;
    micEn  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_sel = 0; m_cyc = 0;
    m_ovf = 1'b0; m_unf = 1'b0;
    m_prev = '0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, '0);
      n_tests++;
      if ({data, fullEn, underflow} !== 10'h0) begin
        n_fail++;
        $display("FAIL mid_after i=%0d got %h want 000",
                 i, {data, fullEn, underflow});
      end
    end
  endtask

  task automatic test_overflow16();
    logic [7:0] exp;
    rst16_n = 1'b1;
    for (int c = 0; c < 17 * 8; c++) begin
      md16 = 48'h0101_0101_0101 * 48'(c / 8 + 1);
      me16 = 1'b1;
      @(negedge clk);
    end
    me16 = 1'b0;
    n_tests++;
    if (ovf16 !== 1'b1 || full16 !== 1'b1 || unf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL d16_full got ovf=%b full=%b unf=%b want 1 1 0",
               ovf16, full16, unf16);
    end
    for (int i = 0; i < 16 * WPB; i++) begin
      exp = 8'(i / WPB + 1);
      n_tests++;
      if (data16 !== exp) begin
        n_fail++;
        $display("FAIL d16_data i=%0d got %h want %h", i, data16, exp);
      end
      if (i == WPB) begin
        n_tests++;
        if (full16 !== 1'b0) begin
          n_fail++;
          $display("FAIL d16_fullen_drop got %b want 0", full16);
        end
      end
      en16 = 1'b1;
      @(negedge clk);
    end
    en16 = 1'b0;
    n_tests++;
    if (data16 !== 8'h00 || unf16 !== 1'b0) begin
      n_fail++;
      $display("FAIL d16_empty got %h/%b want 00/0", data16, unf16);
    end
    en16 = 1'b1;
    @(negedge clk);
    en16 = 1'b0;
    n_tests++;
    if (unf16 !== 1'b1) begin
      n_fail++;
      $display("FAIL d16_unf got %b want 1", unf16);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_read_packet();
    test_drain();
    test_single_word();
    test_micen_off();
    test_pop_on_strobe();
    test_reset_mid_read();
    test_overflow16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
